// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the RV32IM pipeline, placed beside
// the ID stage. It tracks the destination registers of in-flight instructions
// in its own shift-register history. From that history it chooses, in the same
// cycle, the operand selects that the ID/EX register captures. It raises a
// one-cycle stall for load-use pairs.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          synchronous, active-high reset
//   i_id_valid       ID stage holds a real instruction
//   i_rs1_addr/_used source 1 address and "instruction reads rs1"
//   i_rs2_addr/_used source 2 address and "instruction reads rs2"
//   i_id_rd          destination of the ID instruction
//   i_id_reg_write   ID instruction writes rd
//   i_id_is_load     ID instruction is a load
//   i_flush          kill the ID and stage-1 instructions (redirect)
//   i_default_sel1/2 control-unit select, passed through when not forwarding
//   o_fwd_sel1/2     operand select (stage index on a hit, default otherwise)
//   o_fwd_hit1/2     select is a forward stage index
//   o_stall          hold PC/IF/ID and inject a bubble
//   o_hist_valid     valid bit per history entry, bit 0 = entry 1 (newest)
//   o_stall_count    saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned SEL_W      = 2,  // NUM_STAGES must be <= 2**SEL_W - 1
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic                  i_rs1_used,
    input  logic                  i_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_id_rd,
    input  logic                  i_id_reg_write,
    input  logic                  i_id_is_load,
    input  logic                  i_flush,
    input  logic [SEL_W-1:0]      i_default_sel1,
    input  logic [SEL_W-1:0]      i_default_sel2,
    output logic [SEL_W-1:0]      o_fwd_sel1,
    output logic [SEL_W-1:0]      o_fwd_sel2,
    output logic                  o_fwd_hit1,
    output logic                  o_fwd_hit2,
    output logic                  o_stall,
    output logic [NUM_STAGES-1:0] o_hist_valid,
    output logic [CNT_W-1:0]      o_stall_count
);

    // History: index 0 is entry 1 (newest, EX side).
    logic [NUM_STAGES-1:0] r_valid;
    logic [REG_ADDR_W-1:0] r_rd [NUM_STAGES];
    // Only a load in entry 1 changes behaviour, so the is_load bit of the
    // older entries is never kept.
    logic                  r_load1;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [NUM_STAGES-1:0] w_match1;
    logic [NUM_STAGES-1:0] w_match2;
    logic                  w_hit1;
    logic                  w_hit2;
    logic [SEL_W-1:0]      w_idx1;
    logic [SEL_W-1:0]      w_idx2;
    logic                  w_stall;
    logic                  w_push_valid;

    // Per-entry source matches; x0 and unused operands never match.
    always_comb begin
        w_match1 = '0;
        w_match2 = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_match1[k] = i_id_valid & i_rs1_used & (i_rs1_addr != '0) &
                          r_valid[k] & (r_rd[k] == i_rs1_addr);
            w_match2[k] = i_id_valid & i_rs2_used & (i_rs2_addr != '0) &
                          r_valid[k] & (r_rd[k] == i_rs2_addr);
        end
    end

    // Newest match wins. Scanning from oldest to newest lets a newer entry
    // overwrite. A load in entry 1 is the newest producer, but its data is
    // not ready yet. That gives no hit, and it must not fall back to an older
    // (stale) entry.
    always_comb begin
        w_hit1 = 1'b0;
        w_hit2 = 1'b0;
        w_idx1 = '0;
        w_idx2 = '0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (w_match1[k]) begin
                w_hit1 = !((k == 0) && r_load1);
                w_idx1 = SEL_W'(k + 1);
            end
            if (w_match2[k]) begin
                w_hit2 = !((k == 0) && r_load1);
                w_idx2 = SEL_W'(k + 1);
            end
        end
    end

    // Flush beats stall; reset forces everything quiet.
    assign w_stall = ~i_reset & i_id_valid & ~i_flush & r_valid[0] & r_load1 &
                     (w_match1[0] | w_match2[0]);

    assign w_push_valid = i_id_valid & i_id_reg_write & (i_id_rd != '0) &
                          ~w_stall & ~i_flush;

    always_comb begin
        o_fwd_hit1 = w_hit1 & ~i_reset;
        o_fwd_hit2 = w_hit2 & ~i_reset;
        o_fwd_sel1 = o_fwd_hit1 ? w_idx1 : i_default_sel1;
        o_fwd_sel2 = o_fwd_hit2 ? w_idx2 : i_default_sel2;
    end

    assign o_stall       = w_stall;
    assign o_hist_valid  = r_valid;
    assign o_stall_count = r_stall_cnt;

    // Valid bits and the stall counter need reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_valid[0] <= w_push_valid;
            for (int k = 1; k < NUM_STAGES; k++) begin
                // A flushed entry 1 is killed as it moves into entry 2.
                r_valid[k] <= r_valid[k-1] & ((k == 1) ? ~i_flush : 1'b1);
            end
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // Payload only matters when the matching valid bit is set.
    always_ff @(posedge i_clk) begin
        r_rd[0] <= i_id_rd;
        r_load1 <= i_id_is_load;
        for (int k = 1; k < NUM_STAGES; k++) begin
            r_rd[k] <= r_rd[k-1];
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Directed bench for fwd_hazard_unit. A second instance uses a 3-bit stall
// counter, so counter saturation can be reached in a few dozen cycles. Both
// instances share all inputs.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    localparam logic [1:0] DEF1 = 2'd0;
    localparam logic [1:0] DEF2 = 2'd3;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       flush;
    logic [1:0] def_sel1;
    logic [1:0] def_sel2;

    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic        stall;
    logic [2:0]  hist_valid;
    logic [15:0] stall_count;

    logic [1:0]  s_sel1;
    logic [1:0]  s_sel2;
    logic        s_hit1;
    logic        s_hit2;
    logic        s_stall;
    logic [2:0]  s_hist_valid;
    logic [2:0]  s_stall_count;

    int errors = 0;
    int checks = 0;

    fwd_hazard_unit dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_id_valid     (id_valid),
        .i_rs1_addr     (rs1_addr),
        .i_rs2_addr     (rs2_addr),
        .i_rs1_used     (rs1_used),
        .i_rs2_used     (rs2_used),
        .i_id_rd        (id_rd),
        .i_id_reg_write (id_reg_write),
        .i_id_is_load   (id_is_load),
        .i_flush        (flush),
        .i_default_sel1 (def_sel1),
        .i_default_sel2 (def_sel2),
        .o_fwd_sel1     (fwd_sel1),
        .o_fwd_sel2     (fwd_sel2),
        .o_fwd_hit1     (fwd_hit1),
        .o_fwd_hit2     (fwd_hit2),
        .o_stall        (stall),
        .o_hist_valid   (hist_valid),
        .o_stall_count  (stall_count)
    );

    fwd_hazard_unit #(
        .CNT_W (3)
    ) dut_sat (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_id_valid     (id_valid),
        .i_rs1_addr     (rs1_addr),
        .i_rs2_addr     (rs2_addr),
        .i_rs1_used     (rs1_used),
        .i_rs2_used     (rs2_used),
        .i_id_rd        (id_rd),
        .i_id_reg_write (id_reg_write),
        .i_id_is_load   (id_is_load),
        .i_flush        (flush),
        .i_default_sel1 (def_sel1),
        .i_default_sel2 (def_sel2),
        .o_fwd_sel1     (s_sel1),
        .o_fwd_sel2     (s_sel2),
        .o_fwd_hit1     (s_hit1),
        .o_fwd_hit2     (s_hit2),
        .o_stall        (s_stall),
        .o_hist_valid   (s_hist_valid),
        .o_stall_count  (s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one ID-stage instruction; settles before returning.
    task automatic drive(input logic v, input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic fl);
        id_valid     = v;
        rs1_addr     = a1;
        rs1_used     = u1;
        rs2_addr     = a2;
        rs2_used     = u2;
        id_rd        = rd;
        id_reg_write = we;
        id_is_load   = ld;
        flush        = fl;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        def_sel1 = DEF1;
        def_sel2 = DEF2;
        reset    = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;

        // Reset state
        chk("rst_hist", 32'(hist_valid), 32'd0);
        chk("rst_cnt", 32'(stall_count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_hit1", 32'(fwd_hit1), 32'd0);
        chk("rst_sel1", 32'(fwd_sel1), 32'(DEF1));
        chk("rst_sel2", 32'(fwd_sel2), 32'(DEF2));

        // Back-to-back RAW: add x5 then add x6, x5, x7
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("raw_first_nohit", 32'(fwd_hit1), 32'd0);
        cyc();
        drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("raw_sel1", 32'(fwd_sel1), 32'd1);
        chk("raw_hit1", 32'(fwd_hit1), 32'd1);
        chk("raw_hit2", 32'(fwd_hit2), 32'd0);
        chk("raw_sel2", 32'(fwd_sel2), 32'(DEF2));
        chk("raw_stall", 32'(stall), 32'd0);
        chk("raw_hist", 32'(hist_valid), 32'b001);
        cyc();

        // Priority: second write to x5; entries become x5(new), x6, x5(old)
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("prio_sel1", 32'(fwd_sel1), 32'd1);
        chk("prio_hit1", 32'(fwd_hit1), 32'd1);
        chk("prio_sel2", 32'(fwd_sel2), 32'd2);
        chk("prio_hit2", 32'(fwd_hit2), 32'd1);
        chk("prio_hist", 32'(hist_valid), 32'b111);
        cyc();

        // Load-use: lw x8, then add x9, x8, x8
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        chk("lu_lw_nostall", 32'(stall), 32'd0);
        cyc();
        drive(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_stall_hit1", 32'(fwd_hit1), 32'd0);
        chk("lu_stall_hit2", 32'(fwd_hit2), 32'd0);
        chk("lu_stall_sel1", 32'(fwd_sel1), 32'(DEF1));
        chk("lu_stall_sel2", 32'(fwd_sel2), 32'(DEF2));
        chk("lu_cnt_before", 32'(stall_count), 32'd0);
        cyc();
        chk("lu_after_stall", 32'(stall), 32'd0);
        chk("lu_after_sel1", 32'(fwd_sel1), 32'd2);
        chk("lu_after_sel2", 32'(fwd_sel2), 32'd2);
        chk("lu_after_hit1", 32'(fwd_hit1), 32'd1);
        chk("lu_after_hit2", 32'(fwd_hit2), 32'd1);
        chk("lu_cnt", 32'(stall_count), 32'd1);
        cyc();

        // x0 write then x0 read
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("x0_hist", 32'(hist_valid), 32'b010);
        chk("x0_hit1", 32'(fwd_hit1), 32'd0);
        chk("x0_hit2", 32'(fwd_hit2), 32'd0);
        cyc();
        // rs2 matches entry 1 (x10) but is unused
        drive(1'b1, 5'd3, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("unused_hit2", 32'(fwd_hit2), 32'd0);
        chk("unused_sel2", 32'(fwd_sel2), 32'(DEF2));
        chk("unused_hit1", 32'(fwd_hit1), 32'd0);
        cyc();

        // Flush during load-use
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        cyc();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_hit1", 32'(fwd_hit1), 32'd0);
        cyc();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_hist", 32'(hist_valid), 32'b000);
        chk("flush_next_hit1", 32'(fwd_hit1), 32'd0);
        chk("flush_next_stall", 32'(stall), 32'd0);
        chk("flush_cnt", 32'(stall_count), 32'd1);
        cyc();

        // Three more load-use stalls: constant "lw x8, 0(x8)" stalls every
        // other cycle, starting on the second one.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
            chk($sformatf("alt_stall_%0d", i), 32'(stall), 32'(i % 2));
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(12 + i), 1'b1, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_hist", 32'(hist_valid), 32'b111);
        chk("pre_rst_cnt", 32'(stall_count), 32'd4);
        chk("pre_rst_hit1", 32'(fwd_hit1), 32'd1);

        // Mid-stream reset
        reset = 1'b1;
        #1;
        chk("in_rst_hit1", 32'(fwd_hit1), 32'd0);
        chk("in_rst_stall", 32'(stall), 32'd0);
        cyc();
        reset = 1'b0;
        #1;
        chk("post_rst_hist", 32'(hist_valid), 32'd0);
        chk("post_rst_cnt", 32'(stall_count), 32'd0);
        chk("post_rst_hit1", 32'(fwd_hit1), 32'd0);
        chk("post_rst_sel1", 32'(fwd_sel1), 32'(DEF1));
        chk("post_rst_stall", 32'(stall), 32'd0);

        // Saturation: 20 cycles give 10 stalls; 3-bit counter stops at 7
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        repeat (20) cyc();
        chk("sat_main_cnt", 32'(stall_count), 32'd10);
        chk("sat_small_cnt", 32'(s_stall_count), 32'd7);
        repeat (4) cyc();
        chk("sat_main_cnt2", 32'(stall_count), 32'd12);
        chk("sat_small_hold", 32'(s_stall_count), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
